// File: rtl/i2s_codec_responder_if.sv
// Serial audio link between a link master and the codec-side responder,
// plus the parallel word ports on the responder's system side.
interface i2s_codec_responder_if #(
  parameter int N = 24
);
  logic         BCLK;
  logic         LRCLK;
  logic         DAC_SDATA;
  logic [N-1:0] AdcLeftData;
  logic [N-1:0] AdcRightData;
  logic         ADC_SDATA;
  logic [N-1:0] DacLeftData;
  logic [N-1:0] DacRightData;
  logic         DacFrameValid;
  logic         AdcLoad;
  logic         FrameErr;

  modport master (
    output BCLK, LRCLK, DAC_SDATA, AdcLeftData, AdcRightData,
    input  ADC_SDATA, DacLeftData, DacRightData, DacFrameValid, AdcLoad, FrameErr
  );

  modport slave (
    input  BCLK, LRCLK, DAC_SDATA, AdcLeftData, AdcRightData,
    output ADC_SDATA, DacLeftData, DacRightData, DacFrameValid, AdcLoad, FrameErr
  );
endinterface

// File: rtl/i2s_codec_responder.sv
// Codec-side endpoint of the serial audio link: deserializes DAC words from
// the master and serializes captured ADC words back, all in the clk domain.
module i2s_codec_responder #(
  parameter int N        = 24,
  parameter int SLOTS    = 32,
  parameter int MSB_SLOT = 1
) (
  input logic                  clk,
  input logic                  reset,
  i2s_codec_responder_if.slave bus
);
  localparam logic [5:0] FIRST_S = 6'(MSB_SLOT);
  localparam logic [5:0] LAST_S  = 6'(MSB_SLOT + N - 1);
  localparam logic [6:0] SLOTS_S = 7'(SLOTS);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_primed, r_bclk, r_lrclk;
  logic [5:0]   r_slot, w_slot_nxt;
  logic [N-1:0] r_rx, r_tx, r_hold_r, r_dac_l, r_dac_r, w_tx_src;
  logic         r_done, r_left_ok, r_wr_pend, r_wr_right;
  logic         r_adc, r_fv, r_load, r_ferr;
  logic         w_rise, w_fall, w_lr_edge, w_locked, w_rx_slot, w_tx_slot;

  function automatic logic in_data(input logic [5:0] s);
    return (s >= FIRST_S) && (s <= LAST_S) && ({1'b0, s} < SLOTS_S);
  endfunction

  // r_primed keeps a pin level present at reset release from posing as an edge
  assign w_rise    = r_primed & bus.BCLK & ~r_bclk;
  assign w_fall    = r_primed & ~bus.BCLK & r_bclk;
  assign w_lr_edge = w_fall & (bus.LRCLK ^ r_lrclk);
  assign w_locked  = (r_state == ST_LOCKED);

  always_comb begin
    w_state_nxt = r_state;
    if (w_lr_edge) w_state_nxt = ST_LOCKED;
  end

  always_comb begin
    w_slot_nxt = (r_slot == 6'd63) ? r_slot : r_slot + 6'd1;
    if (w_lr_edge) w_slot_nxt = '0;
  end

  assign w_rx_slot = w_locked && in_data(r_slot);
  assign w_tx_slot = (w_locked || w_lr_edge) && in_data(w_slot_nxt);

  // Left word goes straight from the port into the shifter at its capture edge
  always_comb begin
    w_tx_src = r_tx;
    if (w_lr_edge) w_tx_src = bus.LRCLK ? r_hold_r : bus.AdcLeftData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_UNLOCKED;
      r_primed   <= 1'b0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_slot     <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_hold_r   <= '0;
      r_dac_l    <= '0;
      r_dac_r    <= '0;
      r_done     <= 1'b0;
      r_left_ok  <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_right <= 1'b0;
      r_adc      <= 1'b0;
      r_fv       <= 1'b0;
      r_load     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_primed  <= 1'b1;
      r_bclk    <= bus.BCLK;
      r_lrclk   <= bus.LRCLK;
      r_state   <= w_state_nxt;
      r_fv      <= 1'b0;
      r_load    <= 1'b0;
      r_ferr    <= 1'b0;
      r_wr_pend <= 1'b0;

      if (w_fall) begin
        r_slot <= w_slot_nxt;
        if (w_tx_slot) begin
          r_adc <= w_tx_src[N-1];
          r_tx  <= {w_tx_src[N-2:0], 1'b0};
        end else begin
          r_adc <= 1'b0;
          r_tx  <= w_tx_src;
        end
      end

      // A half-frame ending before its word completed is a short half-frame
      if (w_lr_edge) begin
        r_done <= 1'b0;
        r_rx   <= '0;
        if (w_locked && !r_done) begin
          r_ferr    <= 1'b1;
          r_left_ok <= 1'b0;
        end
        if (!bus.LRCLK) begin
          r_hold_r <= bus.AdcRightData;
          r_load   <= 1'b1;
        end
      end

      if (w_rise && w_rx_slot) begin
        r_rx <= {r_rx[N-2:0], bus.DAC_SDATA};
        if (r_slot == LAST_S) begin
          r_wr_pend  <= 1'b1;
          r_wr_right <= r_lrclk;
          r_done     <= 1'b1;
        end
      end

      if (r_wr_pend) begin
        if (r_wr_right) begin
          r_dac_r   <= r_rx;
          r_fv      <= r_left_ok;
          r_left_ok <= 1'b0;
        end else begin
          r_dac_l   <= r_rx;
          r_left_ok <= 1'b1;
        end
      end
    end
  end

  assign bus.ADC_SDATA     = r_adc;
  assign bus.DacLeftData   = r_dac_l;
  assign bus.DacRightData  = r_dac_r;
  assign bus.DacFrameValid = r_fv;
  assign bus.AdcLoad       = r_load;
  assign bus.FrameErr      = r_ferr;
endmodule

// File: tb/tb_i2s_codec_responder.sv
// Bench for i2s_codec_responder: plays half-frames as the link master at
// clk = 4x BCLK and compares against a word/slot-level model of the link.
module tb_i2s_codec_responder;
  localparam int N = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2s_codec_responder_if #(.N(N)) bus ();

  i2s_codec_responder #(.N(N), .SLOTS(32), .MSB_SLOT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int half_no = 0;

  int cnt_fv = 0, cnt_load = 0, cnt_ferr = 0;
  always @(negedge clk) begin
    if (bus.DacFrameValid === 1'b1) cnt_fv++;
    if (bus.AdcLoad === 1'b1) cnt_load++;
    if (bus.FrameErr === 1'b1) cnt_ferr++;
  end

  // Link-level model state
  bit           m_locked, m_left_ok, m_prev_done, m_lr;
  logic [N-1:0] m_dac_l, m_dac_r, m_cap_l, m_cap_r;
  int           exp_fv = 0, exp_load = 0, exp_ferr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_locked    = 1'b0;
    m_left_ok   = 1'b0;
    m_prev_done = 1'b0;
    m_dac_l     = '0;
    m_dac_r     = '0;
    m_cap_l     = '0;
    m_cap_r     = '0;
    m_lr        = bus.LRCLK;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.BCLK = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_dacl", bus.DacLeftData, '0);
    chk("midrst_adc", bus.ADC_SDATA, '0);
    reset = 1'b0;
    model_reset();
  endtask

  // One half-frame of nslots BCLK periods with LRCLK = lr carrying word.
  task automatic half(input bit lr, input logic [N-1:0] word, input int nslots,
                      input bit chg, input logic [N-1:0] chg_val,
                      output logic [63:0] vec);
    logic [63:0]  expv;
    logic [N-1:0] txw;
    bit           lr_edge, done;
    half_no++;
    vec  = '0;
    expv = '0;
    lr_edge = (lr != m_lr);
    m_lr = lr;
    if (lr_edge) begin
      if (m_locked && !m_prev_done) begin
        exp_ferr++;
        m_left_ok = 1'b0;
      end
      m_locked = 1'b1;
      if (!lr) begin
        exp_load++;
        m_cap_l = bus.AdcLeftData;
        m_cap_r = bus.AdcRightData;
      end
    end
    txw = lr ? m_cap_r : m_cap_l;
    if (m_locked)
      for (int s = 1; s <= N && s < 32 && s < nslots; s++) expv[s] = txw[N-s];

    for (int s = 0; s < nslots; s++) begin
      @(negedge clk);
      bus.BCLK      = 1'b0;
      bus.LRCLK     = lr;
      bus.DAC_SDATA = (s >= 1 && s <= N) ? word[N-s] : 1'($urandom);
      if (chg && s == 10) bus.AdcLeftData = chg_val;
      @(negedge clk);
      @(negedge clk);
      bus.BCLK = 1'b1;
      vec[s]   = bus.ADC_SDATA;
      @(negedge clk);
    end

    done = m_locked && (nslots > N);
    if (done) begin
      if (!lr) begin
        m_dac_l   = word;
        m_left_ok = 1'b1;
      end else begin
        m_dac_r = word;
        if (m_left_ok) exp_fv++;
        m_left_ok = 1'b0;
      end
    end
    m_prev_done = done;

    chk($sformatf("h%0d_adc_slots", half_no), vec, expv);
    chk($sformatf("h%0d_dac_left", half_no), bus.DacLeftData, m_dac_l);
    chk($sformatf("h%0d_dac_right", half_no), bus.DacRightData, m_dac_r);
    chk($sformatf("h%0d_frame_valid_cnt", half_no), cnt_fv, exp_fv);
    chk($sformatf("h%0d_adc_load_cnt", half_no), cnt_load, exp_load);
    chk($sformatf("h%0d_frame_err_cnt", half_no), cnt_ferr, exp_ferr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  v;
    logic [N-1:0] l, r;

    reset            = 1'b1;
    bus.BCLK         = 1'b1;
    bus.LRCLK        = 1'b0;
    bus.DAC_SDATA    = 1'b0;
    bus.AdcLeftData  = '0;
    bus.AdcRightData = '0;
    repeat (3) @(negedge clk);
    chk("rst_adc", bus.ADC_SDATA, '0);
    chk("rst_dacl", bus.DacLeftData, '0);
    chk("rst_dacr", bus.DacRightData, '0);
    chk("rst_pulses", {bus.DacFrameValid, bus.AdcLoad, bus.FrameErr}, '0);
    reset = 1'b0;
    model_reset();

    // Unlocked partial left half, then a right half that locks
    bus.AdcLeftData  = 24'h777777;
    bus.AdcRightData = 24'h888888;
    half(1'b0, N'($urandom), 10, 1'b0, '0, v);
    half(1'b1, 24'h3C3C3C, 32, 1'b0, '0, v);

    // Directed loopback frame
    bus.AdcLeftData  = 24'h123456;
    bus.AdcRightData = 24'hFEDCBA;
    half(1'b0, 24'hA5A5A5, 32, 1'b0, '0, v);
    half(1'b1, 24'h5A5A5A, 32, 1'b0, '0, v);

    // Bit ordering on both directions
    bus.AdcLeftData  = 24'h000001;
    bus.AdcRightData = 24'h800001;
    half(1'b0, 24'h800001, 32, 1'b0, '0, v);
    chk("adc_lsb_slot24_only", v, 64'h1 << 24);
    half(1'b1, 24'h000001, 32, 1'b0, '0, v);
    chk("adc_msb_slot1_lsb_slot24", v, (64'h1 << 1) | (64'h1 << 24));

    // Capture timing: mid-left change applies to the following frame
    bus.AdcLeftData  = 24'h111111;
    bus.AdcRightData = 24'h999999;
    half(1'b0, 24'h0F0F0F, 32, 1'b1, 24'h222222, v);
    half(1'b1, 24'hF0F0F0, 32, 1'b0, '0, v);
    half(1'b0, 24'h135799, 32, 1'b0, '0, v);
    half(1'b1, 24'h24680A, 32, 1'b0, '0, v);

    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      bus.AdcLeftData  = N'($urandom);
      bus.AdcRightData = N'($urandom);
      l = N'($urandom);
      r = N'($urandom);
      half(1'b0, l, 32, 1'($urandom), N'($urandom), v);
      half(1'b1, r, 32, 1'b0, '0, v);
    end

    // Short left half, then recovery
    half(1'b0, 24'hDEAD01, 10, 1'b0, '0, v);
    half(1'b1, 24'hBEEF02, 32, 1'b0, '0, v);
    half(1'b0, N'($urandom), 32, 1'b0, '0, v);
    half(1'b1, N'($urandom), 32, 1'b0, '0, v);

    // Long left half: extra slots are silent and raise no error
    bus.AdcLeftData = 24'hFFFFFF;
    half(1'b0, N'($urandom), 40, 1'b0, '0, v);
    half(1'b1, N'($urandom), 32, 1'b0, '0, v);

    // Reset mid-left half, relock on the right edge, then a full frame
    half(1'b0, N'($urandom), 12, 1'b0, '0, v);
    do_reset();
    half(1'b0, N'($urandom), 20, 1'b0, '0, v);
    half(1'b1, N'($urandom), 32, 1'b0, '0, v);
    bus.AdcLeftData  = N'($urandom);
    bus.AdcRightData = N'($urandom);
    half(1'b0, N'($urandom), 32, 1'b0, '0, v);
    half(1'b1, N'($urandom), 32, 1'b0, '0, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_codec_responder.md
Name: i2s_codec_responder

Overview:
- Behavioural and synthesizable codec-side endpoint of the codec serial audio link; the far end of the link master.
- Consumes BCLK, LRCLK and DAC_SDATA from the master and deserializes them into left/right DAC words.
- Serializes supplied left/right ADC words onto ADC_SDATA.
- Used as the loopback/codec model in system benches and as the slave port for FPGA-to-FPGA audio links.

Parameters:
- N, 24, audio word width in bits (data and serial word length).
- SLOTS, 32, BCLK periods per LRCLK half-frame.
- MSB_SLOT, 1, BCLK slot index (0 = first slot after an LRCLK edge) carrying the MSB; 1 gives the standard one-BCLK delay.

Ports:
- clk  input  1  system clock; same source as the master's BCLK generator, at least 4x BCLK frequency.
- reset  input  1  asynchronous, active-high reset.
- BCLK  input  1  bit clock from the master, synchronous to clk.
- LRCLK  input  1  word select; 0 = left, 1 = right; changes only on falling BCLK.
- DAC_SDATA  input  1  serial playback data, MSB first; changes on falling BCLK.
- AdcLeftData  input  N  left word to transmit.
- AdcRightData  input  N  right word to transmit.
- ADC_SDATA  output  1  serial record data, MSB first; changes on falling BCLK.
- DacLeftData  output  N  last complete left word received.
- DacRightData  output  N  last complete right word received.
- DacFrameValid  output  1  one-clk pulse after a right word completes, provided a left word completed in the same frame.
- AdcLoad  output  1  one-clk pulse when AdcLeftData/AdcRightData are captured.
- FrameErr  output  1  one-clk pulse on a short half-frame.

Behaviour:
- Reset values: all outputs 0; internal shift registers 0; slot counter 0; Locked flag 0.
- Edge detection: BCLK and LRCLK are registered once per clk. A rise or fall is detected one clk after the pin transition. No metastability synchronizer is used; the inputs are clk-synchronous.
- Locking: Locked stays 0 until the first LRCLK edge after reset. Before lock, DAC bits are ignored and ADC_SDATA = 0.
- Falling-BCLK events, in priority order:
  - LRCLK edge seen: slot counter <= 0.
  - Otherwise: slot counter increments, saturating at 63.
- Slot k spans from one falling BCLK to the next. Data slots are MSB_SLOT .. MSB_SLOT+N-1. All other slots are don't-care on DAC and drive 0 on ADC.
- DAC receive path:
  - On each detected rising BCLK in a data slot, DAC_SDATA shifts into the receive register LSB-side.
  - At the rising edge of slot MSB_SLOT+N-1, the word is complete. It is written to DacLeftData if LRCLK = 0, otherwise DacRightData, on the next clk.
- Word-complete flags: a left completion sets a left_ok flag. A right completion with left_ok set pulses DacFrameValid on the same clk the DacRightData update becomes visible, then clears left_ok. A right completion without left_ok updates DacRightData with no pulse.
- ADC transmit path:
  - On the LRCLK-edge falling-BCLK event (LRCLK 1->0, i.e. start of left), AdcLeftData and AdcRightData are captured into holding registers and AdcLoad pulses.
  - The captured left word is loaded into the transmit shifter. The captured right word is loaded at the LRCLK 0->1 event.
  - ADC_SDATA is updated on the clk of each detected falling BCLK, giving at least 1 clk of setup before the master's rising-edge sample at a 4x ratio.
  - Slot MSB_SLOT drives bit N-1 and slot MSB_SLOT+N-1 drives bit 0.
- Short half-frame: an LRCLK edge arrives before the current half-frame's word completes while Locked.
  - The partial receive word is discarded; DacLeftData/DacRightData are unchanged and left_ok is cleared.
  - FrameErr pulses and the new half-frame starts normally.
- Long half-frame (more than SLOTS slots): extra slots drive ADC 0 and DAC is ignored; no error is flagged.
- Simultaneous events: an ADC capture and a DacFrameValid pulse on the same clk are independent.
- Mid-frame reset: all state clears immediately and the block relocks at the next LRCLK edge. The first post-reset frame produces DacFrameValid only if its left word is complete.
- Tie-break: a rising and a falling BCLK cannot be detected on the same clk. This is guaranteed by the 4x minimum ratio.

Test Plan:
- Loopback with the team's link master at clk = 4x BCLK. Master plays L=24'hA5A5A5, R=24'h5A5A5A -> DacLeftData=24'hA5A5A5 and DacRightData=24'h5A5A5A with one DacFrameValid pulse per frame. Response words AdcLeftData=24'h123456, AdcRightData=24'hFEDCBA -> master's LeftRecData=24'h123456, RightRecData=24'hFEDCBA.
- Bit ordering, DAC side: playback word 24'h800001 -> ADC_SDATA and DAC_SDATA MSB in slot 1, LSB in slot 24; slots 0 and 25-31 of ADC_SDATA = 0.
- Bit ordering, ADC side: transmit word 24'h000001 -> ADC_SDATA high only in slot 24 of the left half.
- Lock: assert reset mid-left-half, release -> no DacFrameValid and ADC_SDATA=0 until after the first LRCLK edge; the first full frame yields a valid pulse.
- Short half-frame: toggle LRCLK after 10 BCLKs -> FrameErr pulses once, DacLeftData unchanged, no DacFrameValid for that frame; the next normal frame recovers.
- ADC capture timing: change AdcLeftData mid-left-half from 24'h111111 to 24'h222222 -> the current frame transmits 24'h111111, the next frame 24'h222222; AdcLoad pulses exactly once per frame.
